// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IWAIT = 2'd1;
    localparam logic [1:0] ST_DWAIT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // A limit of 0 still needs a 1-bit counter so the port list stays legal.
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of contested data grants; flags when fetch must win next.
module starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam int unsigned   CNT_W   = starve_cnt_w(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve = (LIMIT != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-ported, variable-latency memory.
// Data wins contested grants unless the starvation counter hands the slot to fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdata,
    output logic              IReady,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DReady,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemAck,
    output logic              StallFetch,
    output logic              StallMem
);

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] irdata_q,    irdata_d;
    logic [DATA_W-1:0] drdata_q,    drdata_d;
    logic              iready_q,    iready_d;
    logic              dready_q,    dready_d;

    logic starve;
    logic win_dat;
    logic win_ins;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        iready_d    = 1'b0;
        dready_d    = 1'b0;
        win_dat     = 1'b0;
        win_ins     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (DReq && (!IReq || !starve)) begin
                    win_dat     = 1'b1;
                    state_d     = ST_DWAIT;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DWe;
                    mem_addr_d  = DAddr;
                    mem_wdata_d = DWdata;
                end else if (IReq) begin
                    win_ins    = 1'b1;
                    state_d    = ST_IWAIT;
                    owner_d    = OWN_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IAddr;
                end
            end
            ST_IWAIT, ST_DWAIT: begin
                if (MemAck) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        dready_d = 1'b1;
                        // A store leaves the last load value visible to the pipeline.
                        if (!mem_we_q) begin
                            drdata_d = MemRdata;
                        end
                    end else begin
                        iready_d = 1'b1;
                        irdata_d = MemRdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            iready_q    <= 1'b0;
            dready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            iready_q    <= iready_d;
            dready_q    <= dready_d;
        end
    end

    // Only contested data wins count toward starvation.
    starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (win_dat && IReq),
        .clr    (win_ins),
        .starve (starve)
    );

    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWdata   = mem_wdata_q;
    assign IRdata     = irdata_q;
    assign DRdata     = drdata_q;
    assign IReady     = iready_q;
    assign DReady     = dready_q;
    assign StallFetch = IReq && !iready_q;
    assign StallMem   = DReq && !dready_q;

endmodule
